// File: rtl/vram_sched_pkg.sv
// Shared types, widths and helpers for the VRAM request scheduler.
package vram_sched_pkg;

  localparam int unsigned ADDR_W = 23;

  // Transfer width codes understood by the memory controller.
  localparam logic [1:0] MEMORY_WIDTH_8  = 2'd0;
  localparam logic [1:0] MEMORY_WIDTH_16 = 2'd1;
  localparam logic [1:0] MEMORY_WIDTH_32 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REF  = 2'd1,
    GNT_A    = 2'd2,
    GNT_B    = 2'd3
  } grant_t;

  // Bookkeeping for one outstanding read travelling down the latency pipe.
  typedef struct packed {
    logic       vld;
    logic       is_b;
    logic       byte_sel;
    logic [1:0] size;
  } rd_tag_t;

  // Refresh interval in clocks: freq_hz * interval_ns / 1e9, truncated.
  function automatic int unsigned refresh_cycles(input int unsigned freq_hz,
                                                 input int unsigned interval_ns);
    longint unsigned prod;
    prod = 64'(freq_hz) * 64'(interval_ns);
    return 32'(prod / 64'd1_000_000_000);
  endfunction

endpackage

// File: rtl/vram_refresh_timer.sv
// Free-running refresh down-counter with pending and sticky overdue flags.
module vram_refresh_timer #(
  parameter int unsigned CYCLES = 842
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pending,
  output logic overdue
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             expire_c;

  assign expire_c = (count == '0);

  // Count down every cycle; on expiry reload, raise pending, flag a missed slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= RELOAD;
      pending <= 1'b0;
      overdue <= 1'b0;
    end else begin
      count   <= expire_c ? RELOAD : count - CNT_W'(1);
      pending <= expire_c | (pending & ~clear);
      if (expire_c && pending && !clear) begin
        overdue <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_request_scheduler.sv
// Arbitrates refresh, client A (CPU, 8-bit) and client B (command engine,
// 8/16/32-bit) onto the VRAM controller, one request per slot.
// Optional build macro VRAM_SCHED_ROUND_ROBIN_EN: alternate A/B on ties
// instead of strict A-over-B priority.
module vram_request_scheduler
  import vram_sched_pkg::*;
#(
  parameter int unsigned FREQ        = 54_000_000,
  parameter int unsigned REFRESH_NS  = 15_600,
  parameter int unsigned SLOT_CYCLES = 5,
  parameter int unsigned RD_LATENCY  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enabled,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_word_wr_size,
  output logic [7:0]        mem_din8,
  output logic [15:0]       mem_din16,
  output logic [31:0]       mem_din32,
  input  logic [15:0]       mem_dout16,
  input  logic [31:0]       mem_dout32,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_din,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [1:0]        b_size,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_din,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              b_rvalid,
  output logic              refresh_overdue
);

  localparam int unsigned REFRESH_CYCLES = refresh_cycles(FREQ, REFRESH_NS);
  localparam int unsigned SLOT_W         = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  // Slot position counts from the ISSUE cycle (0); the final position of a
  // slot is spent in IDLE deciding the next grant, so WAIT ends one earlier.
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 2);

  state_t            state;
  state_t            state_next;
  grant_t            grant_c;
  logic [SLOT_W-1:0] slot_cnt;
  logic              ref_pending;
  logic              iss_b;
  rd_tag_t           rd_tag_c;
  rd_tag_t           rd_out;
  rd_tag_t           rd_pipe [RD_LATENCY];
  logic [7:0]        rd_byte_c;
  logic [31:0]       b_word_c;

  vram_refresh_timer #(
    .CYCLES (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_c == GNT_REF),
    .pending (ref_pending),
    .overdue (refresh_overdue)
  );

`ifdef VRAM_SCHED_ROUND_ROBIN_EN
  logic last_b;

  // Remember which client won last; starts as B so A takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (grant_c == GNT_A) begin
      last_b <= 1'b0;
    end else if (grant_c == GNT_B) begin
      last_b <= 1'b1;
    end
  end
`endif

  // State register and slot position counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      slot_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ISSUE) begin
        slot_cnt <= SLOT_W'(1);
      end else if (state == WAIT) begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Next state and grant selection: refresh first, then the clients.
  always_comb begin
    state_next = state;
    grant_c    = GNT_NONE;
    case (state)
      IDLE: begin
        if (mem_enabled) begin
          if (ref_pending) grant_c = GNT_REF;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
          else if (a_req && b_req) grant_c = last_b ? GNT_A : GNT_B;
`else
          else if (a_req && b_req) grant_c = GNT_A;
`endif
          else if (a_req) grant_c = GNT_A;
          else if (b_req) grant_c = GNT_B;
          if (grant_c != GNT_NONE) state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (slot_cnt == SLOT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register the granted request onto the controller bus and ack the client.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_refresh      <= 1'b0;
      mem_addr         <= '0;
      mem_word_wr_size <= MEMORY_WIDTH_8;
      mem_din8         <= '0;
      mem_din16        <= '0;
      mem_din32        <= '0;
      a_ack            <= 1'b0;
      b_ack            <= 1'b0;
      iss_b            <= 1'b0;
    end else begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_refresh <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      case (grant_c)
        GNT_REF: begin
          mem_refresh      <= 1'b1;
          mem_addr         <= '0;
          mem_word_wr_size <= MEMORY_WIDTH_8;
          mem_din8         <= '0;
          mem_din16        <= '0;
          mem_din32        <= '0;
        end
        GNT_A: begin
          mem_read         <= ~a_wr;
          mem_write        <= a_wr;
          mem_addr         <= a_addr;
          mem_word_wr_size <= MEMORY_WIDTH_8;
          mem_din8         <= a_din;
          mem_din16        <= {8'h00, a_din};
          mem_din32        <= {24'h00_0000, a_din};
          a_ack            <= 1'b1;
          iss_b            <= 1'b0;
        end
        GNT_B: begin
          mem_read         <= ~b_wr;
          mem_write        <= b_wr;
          mem_addr         <= b_addr;
          mem_word_wr_size <= b_size;
          mem_din8         <= b_din[7:0];
          mem_din16        <= b_din[15:0];
          mem_din32        <= b_din;
          b_ack            <= 1'b1;
          iss_b            <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The issue edge is the edge that samples mem_read; the tag enters the pipe
  // there and reaches the last stage RD_LATENCY edges later, with data valid.
  assign rd_tag_c = {mem_read, iss_b, mem_addr[0], mem_word_wr_size};
  assign rd_out   = rd_pipe[RD_LATENCY-1];

  // Read latency pipe; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_tag_c;
      for (int i = 1; i < int'(RD_LATENCY); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Byte lane select and width formatting of returned data.
  always_comb begin
    rd_byte_c = rd_out.byte_sel ? mem_dout16[15:8] : mem_dout16[7:0];
    case (rd_out.size)
      MEMORY_WIDTH_32: b_word_c = mem_dout32;
      MEMORY_WIDTH_16: b_word_c = {16'h0000, mem_dout16};
      default:         b_word_c = {24'h00_0000, rd_byte_c};
    endcase
  end

  // Capture read data and pulse the owning client's rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (rd_out.vld) begin
        if (rd_out.is_b) begin
          b_rvalid <= 1'b1;
          b_rdata  <= b_word_c;
        end else begin
          a_rvalid <= 1'b1;
          a_rdata  <= rd_byte_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_request_scheduler.sv
// Directed bench for vram_request_scheduler (refresh period 100 clocks).
module tb_vram_request_scheduler;

  logic        clk;
  logic        reset;
  logic        mem_enabled;
  logic        mem_read;
  logic        mem_write;
  logic        mem_refresh;
  logic [22:0] mem_addr;
  logic [1:0]  mem_word_wr_size;
  logic [7:0]  mem_din8;
  logic [15:0] mem_din16;
  logic [31:0] mem_din32;
  logic [15:0] mem_dout16;
  logic [31:0] mem_dout32;
  logic        a_req;
  logic        a_wr;
  logic [22:0] a_addr;
  logic [7:0]  a_din;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        a_rvalid;
  logic        b_req;
  logic        b_wr;
  logic [1:0]  b_size;
  logic [22:0] b_addr;
  logic [31:0] b_din;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic        refresh_overdue;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rbase    = 0;

  vram_request_scheduler #(
    .FREQ        (1_000_000_000),
    .REFRESH_NS  (100),
    .SLOT_CYCLES (5),
    .RD_LATENCY  (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_enabled      (mem_enabled),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_refresh      (mem_refresh),
    .mem_addr         (mem_addr),
    .mem_word_wr_size (mem_word_wr_size),
    .mem_din8         (mem_din8),
    .mem_din16        (mem_din16),
    .mem_din32        (mem_din32),
    .mem_dout16       (mem_dout16),
    .mem_dout32       (mem_dout32),
    .a_req            (a_req),
    .a_wr             (a_wr),
    .a_addr           (a_addr),
    .a_din            (a_din),
    .a_ack            (a_ack),
    .a_rdata          (a_rdata),
    .a_rvalid         (a_rvalid),
    .b_req            (b_req),
    .b_wr             (b_wr),
    .b_size           (b_size),
    .b_addr           (b_addr),
    .b_din            (b_din),
    .b_ack            (b_ack),
    .b_rdata          (b_rdata),
    .b_rvalid         (b_rvalid),
    .refresh_overdue  (refresh_overdue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rbase = cyc;
  endtask

  // Step until any request pulse is seen; k is clocks since reset release, -1 on timeout.
  task automatic wait_pulse(input int budget, output int k);
    k = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (mem_read || mem_write || mem_refresh) begin
        k = cyc - rbase;
        break;
      end
    end
  endtask

  // One client read; data is valid on the bus only in the single cycle before
  // the edge five clocks after the edge that samples mem_read.
  task automatic do_read(input string tag, input logic is_b, input logic [1:0] sz,
                         input logic [22:0] addr, input logic [15:0] d16,
                         input logic [31:0] d32, input logic [31:0] exp);
    int early;
    if (is_b) begin
      b_wr = 1'b0; b_size = sz; b_addr = addr; b_req = 1'b1;
    end else begin
      a_wr = 1'b0; a_addr = addr; a_req = 1'b1;
    end
    step();
    chk({tag, " pulse"}, 32'({mem_read, mem_write, mem_refresh}), 32'(3'b100));
    chk({tag, " ack"}, 32'({a_ack, b_ack}), is_b ? 32'(2'b01) : 32'(2'b10));
    a_req = 1'b0;
    b_req = 1'b0;
    early = 0;
    repeat (5) begin
      step();
      early += int'(a_rvalid | b_rvalid);
    end
    mem_dout16 = d16;
    mem_dout32 = d32;
    step();
    mem_dout16 = 16'h5A5A;
    mem_dout32 = 32'hDEAD_BEEF;
    chk({tag, " early rvalid"}, 32'(early), 32'(0));
    chk({tag, " rvalid"}, 32'({a_rvalid, b_rvalid}), is_b ? 32'(2'b01) : 32'(2'b10));
    chk({tag, " rdata"}, is_b ? b_rdata : 32'(a_rdata), exp);
    step();
    chk({tag, " rvalid once"}, 32'({a_rvalid, b_rvalid}), 32'(0));
  endtask

  initial begin
    int k;
    int cnt;
    int ks [4];
    logic [3:0] pat;
    logic [3:0] exp_pat;

    reset = 1'b1; mem_enabled = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_wr = 1'b0; b_size = 2'd0; b_addr = '0; b_din = '0;
    mem_dout16 = 16'h5A5A; mem_dout32 = 32'hDEAD_BEEF;

    // Reset state
    do_reset();
    chk("rst pulses", 32'({mem_read, mem_write, mem_refresh}), 32'(0));
    chk("rst acks", 32'({a_ack, b_ack}), 32'(0));
    chk("rst rvalids", 32'({a_rvalid, b_rvalid}), 32'(0));
    chk("rst a_rdata", 32'(a_rdata), 32'(0));
    chk("rst b_rdata", b_rdata, 32'(0));
    chk("rst overdue", 32'(refresh_overdue), 32'(0));

    // A byte write
    mem_enabled = 1'b1;
    a_wr = 1'b1; a_addr = 23'h00011; a_din = 8'hA5; a_req = 1'b1;
    step();
    chk("a wr pulse", 32'({mem_read, mem_write, mem_refresh}), 32'(3'b010));
    chk("a wr addr", 32'(mem_addr), 32'h00011);
    chk("a wr size", 32'(mem_word_wr_size), 32'(0));
    chk("a wr din8", 32'(mem_din8), 32'hA5);
    chk("a wr acks", 32'({a_ack, b_ack}), 32'(2'b10));
    a_req = 1'b0;
    cnt = 0;
    repeat (4) begin
      step();
      cnt += int'(mem_read | mem_write | mem_refresh | a_ack);
    end
    chk("a wr quiet slot", 32'(cnt), 32'(0));

    // B 16-bit write: all din buses from b_din
    b_wr = 1'b1; b_size = 2'd1; b_addr = 23'h00456; b_din = 32'hCAFE_F00D; b_req = 1'b1;
    step();
    chk("b wr pulse", 32'({mem_read, mem_write, mem_refresh}), 32'(3'b010));
    chk("b wr addr", 32'(mem_addr), 32'h00456);
    chk("b wr size", 32'(mem_word_wr_size), 32'(1));
    chk("b wr din8", 32'(mem_din8), 32'h0D);
    chk("b wr din16", 32'(mem_din16), 32'hF00D);
    chk("b wr din32", mem_din32, 32'hCAFE_F00D);
    chk("b wr acks", 32'({a_ack, b_ack}), 32'(2'b01));
    b_req = 1'b0;
    repeat (4) step();

    // Reads: odd/even byte lanes, 32-bit and 8-bit B
    do_read("a rd odd", 1'b0, 2'd0, 23'h00003, 16'hBEEF, 32'h0, 32'h0000_00BE);
    do_read("a rd even", 1'b0, 2'd0, 23'h00008, 16'h1234, 32'h0, 32'h0000_0034);
    do_read("b rd32", 1'b1, 2'd2, 23'h00100, 16'h0, 32'h1234_5678, 32'h1234_5678);
    do_read("b rd8 odd", 1'b1, 2'd0, 23'h00103, 16'h7788, 32'h0, 32'h0000_0077);

    // Both clients continuously requesting
    do_reset();
    mem_enabled = 1'b1;
    a_wr = 1'b1; a_addr = 23'h000AA; a_din = 8'h11;
    b_wr = 1'b1; b_size = 2'd0; b_addr = 23'h000BB; b_din = 32'h22;
    a_req = 1'b1; b_req = 1'b1;
    pat = '0;
    for (int s = 0; s < 4; s++) begin
      wait_pulse(10, ks[s]);
      pat = {pat[2:0], b_ack};
    end
    a_req = 1'b0; b_req = 1'b0;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b0000;
`endif
    chk("arb order", 32'(pat), 32'(exp_pat));
    chk("arb first issue", 32'(ks[0]), 32'(1));
    chk("arb gap1", 32'(ks[1] - ks[0]), 32'(5));
    chk("arb gap2", 32'(ks[2] - ks[1]), 32'(5));
    chk("arb gap3", 32'(ks[3] - ks[2]), 32'(5));
    repeat (4) step();

    // Refresh cadence, overdue while disabled, single catch-up refresh
    do_reset();
    mem_enabled = 1'b1;
    wait_pulse(150, k);
    chk("ref1 time", 32'(k), 32'(101));
    chk("ref1 kind", 32'({mem_read, mem_write, mem_refresh}), 32'(3'b001));
    chk("ref1 acks", 32'({a_ack, b_ack}), 32'(0));
    chk("ref1 overdue", 32'(refresh_overdue), 32'(0));
    wait_pulse(150, k);
    chk("ref2 time", 32'(k), 32'(201));
    mem_enabled = 1'b0;
    cnt = 0;
    repeat (250) begin
      step();
      cnt += int'(mem_read | mem_write | mem_refresh);
    end
    chk("disabled pulses", 32'(cnt), 32'(0));
    chk("overdue set", 32'(refresh_overdue), 32'(1));
    mem_enabled = 1'b1;
    cnt = 0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (mem_refresh) begin
        cnt++;
        if (k < 0) k = i;
      end
    end
    chk("reenable ref count", 32'(cnt), 32'(1));
    chk("reenable ref delay", 32'(k), 32'(1));
    chk("overdue sticky", 32'(refresh_overdue), 32'(1));

    // Reset two cycles after an A read issue
    do_reset();
    mem_enabled = 1'b1;
    a_wr = 1'b0; a_addr = 23'h00005; a_req = 1'b1;
    step();
    chk("rst-mid issue", 32'(mem_read), 32'(1));
    a_req = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rbase = cyc;
    chk("rst-mid pulses", 32'({mem_read, mem_write, mem_refresh}), 32'(0));
    chk("rst-mid addr", 32'(mem_addr), 32'(0));
    chk("rst-mid acks", 32'({a_ack, b_ack}), 32'(0));
    chk("rst-mid overdue", 32'(refresh_overdue), 32'(0));
    mem_dout16 = 16'hBEEF;
    cnt = 0;
    repeat (10) begin
      step();
      cnt += int'(a_rvalid | b_rvalid);
    end
    chk("rst-mid no rvalid", 32'(cnt), 32'(0));
    wait_pulse(150, k);
    chk("rst-mid ref time", 32'(k), 32'(101));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_request_scheduler.md
Name: vram_request_scheduler

Overview:
- Initiator side of the VRAM memory-controller request interface (read/write/refresh pulses, addr, word_wr_size, din8/16/32, dout16/dout32).
- Arbitrates two VDP clients (A: CPU port, 8-bit; B: command engine, 8/16/32-bit) and an internal refresh timer.
- Issues at most one single-cycle request per slot and captures read data at the controller's fixed latency.
- Sits between the VDP core and the memory controller.

Parameters:
- FREQ, 54_000_000: clk frequency in Hz.
- REFRESH_NS, 15_600: refresh interval in ns; REFRESH_CYCLES = FREQ/1e9*REFRESH_NS, truncated.
- SLOT_CYCLES, 5: minimum clocks from one issue to the next issue.
- RD_LATENCY, 5: clocks from a read issue edge to the edge where mem_dout16/mem_dout32 are valid.

Ports:
- clk  in  1  main logic clock
- reset  in  1  synchronous, active-high
- mem_enabled  in  1  controller finished init; no issue while 0
- mem_read / mem_write / mem_refresh  out  1 each  single-cycle request pulses, mutually exclusive
- mem_addr  out  23  byte address
- mem_word_wr_size  out  2  MEMORY_WIDTH_8/16/32
- mem_din8  out  8; mem_din16  out  16; mem_din32  out  32  write data
- mem_dout16  in  16; mem_dout32  in  32  read data
- a_req  in  1; a_wr  in  1; a_addr  in  23; a_din  in  8
- a_ack  out  1; a_rdata  out  8; a_rvalid  out  1
- b_req  in  1; b_wr  in  1; b_size  in  2; b_addr  in  23; b_din  in  32
- b_ack  out  1; b_rdata  out  32; b_rvalid  out  1
- refresh_overdue  out  1  sticky status flag

Behaviour:
- Reset (sync, active-high): all pulses 0; a_ack, b_ack, a_rvalid, b_rvalid 0; rdata 0; refresh_overdue 0; state IDLE; refresh timer reloaded to REFRESH_CYCLES-1; refresh_pending 0. A reset mid-operation abandons it: no ack and no rvalid follow.
- States:
  - IDLE: waits for mem_enabled=1 and any source pending.
  - ISSUE: one cycle. Drives exactly one pulse plus addr/size/data. Pulses the chosen client's ack the same cycle. Client request fields are latched into internal registers.
  - WAIT: slot counter runs to SLOT_CYCLES-1, then returns to IDLE. A new ISSUE is allowed on the next cycle, giving a 5-cycle back-to-back cadence.
- Priority: refresh_pending > A > B (see optional feature).
- Client handshake:
  - Client holds req and its fields stable until ack.
  - ack is a 1-cycle pulse; req may drop the cycle after.
  - req deasserted before ack is a legal withdrawal.
- Writes:
  - A: size MEMORY_WIDTH_8, mem_din8=a_din.
  - B: size=b_size. din8=b_din[7:0], din16=b_din[15:0], din32=b_din.
  - All three din buses are always driven from the same source.
- Reads:
  - Read data is sampled exactly RD_LATENCY clocks after the issue edge. The owning rvalid pulses 1 cycle with the data registered.
  - a_rdata = addr[0] ? mem_dout16[15:8] : mem_dout16[7:0].
  - b_rdata = mem_dout32 for size 32, {16'b0, mem_dout16} for 16, zero-extended byte for 8.
- Refresh timer:
  - Counts down every cycle, including while busy. At 0 it reloads and sets refresh_pending.
  - Issuing mem_refresh clears refresh_pending. No ack or rvalid is associated.
  - Expiry while refresh_pending is already 1 sets refresh_overdue, which stays set until reset.
  - Expiry coincident with an ISSUE of a client request: pending is set and served next slot.
- mem_enabled low: requests are held pending; the timer still runs.
- Address: passed through unmodified (23 bits); no wrap logic.

Optional Feature:
- Macro VRAM_SCHED_ROUND_ROBIN_EN.
- Defined: when A and B are both pending, and refresh is not, the client not served last wins. The last-served flag resets to B, so A wins the first tie.
- Undefined: strict A > B; B can starve under continuous A traffic.
- Refresh priority is unchanged in both builds.

Decomposition:
- Package vram_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT)
  - grant enum (GNT_NONE, GNT_REF, GNT_A, GNT_B)
  - function computing REFRESH_CYCLES
  - MEMORY_WIDTH_* from vdp_constants.vh
- Sub-module vram_refresh_timer: down-counter, pending and overdue flags, clear input.

Test Plan:
- Reset, mem_enabled=1, a_req write a_addr=0x00011, a_din=0xA5 -> one mem_write, addr 0x00011, size 8, din8=0xA5; a_ack same cycle; no further pulse for 4 cycles.
- A read addr 0x00003 with mem_dout16=0xBEEF at issue+5 -> a_rvalid at issue+6, a_rdata=0xBE.
- B 32-bit read addr 0x00100, mem_dout32=0x12345678 at issue+5 -> b_rvalid once, b_rdata=0x12345678; a_rvalid stays 0.
- A and B both requesting continuously for 4 slots -> strict build: AAAA; round-robin build: ABAB; issues exactly 5 cycles apart.
- FREQ=1e9, REFRESH_NS=100, no client traffic -> mem_refresh every 100 cycles. Then mem_enabled=0 for 250 cycles -> refresh_overdue=1, no pulses; after re-enable one refresh issues.
- Assert reset 2 cycles after an A read issue -> no a_rvalid; all outputs 0 next cycle; timer restarts at REFRESH_CYCLES-1.
